// File: rtl/seq_hamming_cmp_if.sv
// Compare request/result bundle for seq_hamming_cmp.
// The master launches compares; the slave returns status and the verdict.
interface seq_hamming_cmp_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic [DW-1:0]    thresh;
    logic             busy;
    logic             done;
    logic [DW-1:0]    distance;
    logic             match;

    modport master (
        output start, a, b, mode, thresh,
        input  busy, done, distance, match
    );

    modport slave (
        input  start, a, b, mode, thresh,
        output busy, done, distance, match
    );
endinterface

// File: rtl/seq_hamming_cmp.sv
// Multi-cycle Hamming-distance comparator: scans LANES bits per cycle and
// issues an EQ / LE / GE / ODD verdict on the accumulated distance.
module seq_hamming_cmp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input logic             clk,
    input logic             rst_n,
    seq_hamming_cmp_if.slave io_cmp
);
    localparam int unsigned DW = $clog2(WIDTH + 1);
    localparam int unsigned N  = WIDTH / LANES;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_LE = 2'b01;
    localparam logic [1:0] MODE_GE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a,        w_a_nxt;
    logic [WIDTH-1:0] r_b,        w_b_nxt;
    logic [1:0]       r_mode,     w_mode_nxt;
    logic [DW-1:0]    r_thresh,   w_thresh_nxt;
    logic [DW-1:0]    r_acc,      w_acc_nxt;
    logic [KW-1:0]    r_k,        w_k_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic [DW-1:0]    r_distance, w_distance_nxt;
    logic             r_match,    w_match_nxt;

    logic [WIDTH-1:0] w_diff;
    logic [LANES-1:0] w_slice;
    logic [DW-1:0]    w_pop;
    logic             w_last;

    // Popcount of the current LANES-wide slice of the operand difference
    always_comb begin
        w_diff  = r_a ^ r_b;
        w_slice = LANES'(w_diff >> (32'(r_k) * LANES));
        w_pop   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_pop = w_pop + DW'(w_slice[i]);
        end
        w_last  = (r_k == KW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-register values; busy is set one edge ahead so it tracks RUN
    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_mode_nxt     = r_mode;
        w_thresh_nxt   = r_thresh;
        w_acc_nxt      = r_acc;
        w_k_nxt        = r_k;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_distance_nxt = r_distance;
        w_match_nxt    = r_match;

        case (r_state)
            S_IDLE: begin
                if (io_cmp.start) begin
                    w_a_nxt      = io_cmp.a;
                    w_b_nxt      = io_cmp.b;
                    w_mode_nxt   = io_cmp.mode;
                    w_thresh_nxt = io_cmp.thresh;
                    w_acc_nxt    = '0;
                    w_k_nxt      = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                w_acc_nxt = r_acc + w_pop;
                w_k_nxt   = r_k + KW'(1);
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            S_FIN: begin
                w_distance_nxt = r_acc;
                w_done_nxt     = 1'b1;
                w_state_nxt    = S_IDLE;
                case (r_mode)
                    MODE_EQ: w_match_nxt = (r_acc == '0);
                    MODE_LE: w_match_nxt = (r_acc <= r_thresh);
                    MODE_GE: w_match_nxt = (r_acc >= r_thresh);
                    default: w_match_nxt = r_acc[0];
                endcase
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= '0;
            r_thresh   <= '0;
            r_acc      <= '0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_distance <= '0;
            r_match    <= 1'b0;
        end else begin
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_mode     <= w_mode_nxt;
            r_thresh   <= w_thresh_nxt;
            r_acc      <= w_acc_nxt;
            r_k        <= w_k_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_distance <= w_distance_nxt;
            r_match    <= w_match_nxt;
        end
    end

    assign io_cmp.busy     = r_busy;
    assign io_cmp.done     = r_done;
    assign io_cmp.distance = r_distance;
    assign io_cmp.match    = r_match;
endmodule

// File: tb/tb_seq_hamming_cmp.sv
// Bench for seq_hamming_cmp: three geometries (8/1, 16/4, 8/2) against a
// bit-counting reference model, with directed cases plus random compares.
module tb_seq_hamming_cmp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_start = 1'b0;
    logic [15:0] t_a = '0;
    logic [15:0] t_b = '0;
    logic [1:0]  t_mode = '0;
    logic [4:0]  t_thresh = '0;
    int          sel = 0;

    int n_chk = 0;
    int n_fail = 0;
    int prev_d[3];
    int prev_m[3];

    logic       o_busy, o_done, o_match;
    logic [4:0] o_dist;

    always #5 clk = ~clk;

    seq_hamming_cmp_if #(.WIDTH(8))  if0 ();
    seq_hamming_cmp_if #(.WIDTH(16)) if1 ();
    seq_hamming_cmp_if #(.WIDTH(8))  if2 ();

    assign if0.start  = t_start && (sel == 0);
    assign if0.a      = t_a[7:0];
    assign if0.b      = t_b[7:0];
    assign if0.mode   = t_mode;
    assign if0.thresh = t_thresh[3:0];
    assign if1.start  = t_start && (sel == 1);
    assign if1.a      = t_a;
    assign if1.b      = t_b;
    assign if1.mode   = t_mode;
    assign if1.thresh = t_thresh;
    assign if2.start  = t_start && (sel == 2);
    assign if2.a      = t_a[7:0];
    assign if2.b      = t_b[7:0];
    assign if2.mode   = t_mode;
    assign if2.thresh = t_thresh[3:0];

    seq_hamming_cmp #(.WIDTH(8),  .LANES(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .io_cmp(if0));
    seq_hamming_cmp #(.WIDTH(16), .LANES(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_cmp(if1));
    seq_hamming_cmp #(.WIDTH(8),  .LANES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .io_cmp(if2));

    always_comb begin
        case (sel)
            0: begin
                o_busy = if0.busy; o_done = if0.done;
                o_dist = {1'b0, if0.distance}; o_match = if0.match;
            end
            1: begin
                o_busy = if1.busy; o_done = if1.done;
                o_dist = if1.distance; o_match = if1.match;
            end
            default: begin
                o_busy = if2.busy; o_done = if2.done;
                o_dist = {1'b0, if2.distance}; o_match = if2.match;
            end
        endcase
    end

    function automatic int wid(input int s);
        return (s == 1) ? 16 : 8;
    endfunction

    function automatic int lanes(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 4 : 2);
    endfunction

    function automatic int dwid(input int s);
        return (s == 1) ? 5 : 4;
    endfunction

    function automatic int ham(input logic [15:0] x, input logic [15:0] y, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) if (x[i] != y[i]) n++;
        return n;
    endfunction

    function automatic int verdict(input int m, input int d, input int th);
        case (m)
            0:       return (d == 0) ? 1 : 0;
            1:       return (d <= th) ? 1 : 0;
            2:       return (d >= th) ? 1 : 0;
            default: return d % 2;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
        end
    endtask

    // One full compare with ignored starts and operand churn during RUN/FIN
    task automatic do_cmp(input int s, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] m, input int th);
        int n = wid(s) / lanes(s);
        int d = ham(a, b, wid(s));
        int mt = verdict(int'(m), d, th);
        @(negedge clk);
        sel = s; t_a = a; t_b = b; t_mode = m; t_thresh = 5'(th); t_start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("busy_run", o_busy, 1);
            check("done_run", o_done, 0);
            check("dist_hold_run", o_dist, prev_d[s]);
            t_start = 1'($urandom % 2);
            t_a = 16'($urandom);
            t_b = 16'($urandom);
        end
        @(negedge clk);
        check("busy_fin", o_busy, 0);
        check("done_fin", o_done, 0);
        check("dist_hold_fin", o_dist, prev_d[s]);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        check("done_pulse", o_done, 1);
        check("busy_done", o_busy, 0);
        check("distance", o_dist, d);
        check("match", o_match, mt);
        prev_d[s] = d;
        prev_m[s] = mt;
        @(negedge clk);
        check("done_clear", o_done, 0);
        check("busy_idle", o_busy, 0);
        check("dist_hold", o_dist, d);
        check("match_hold", o_match, mt);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            prev_d[s] = 0;
            prev_m[s] = 0;
        end
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_dist", o_dist, 0);
            check("rst_match", o_match, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_cmp(0, 16'h00A5, 16'h00A5, 2'b00, 0);
        do_cmp(0, 16'h00FF, 16'h00F0, 2'b01, 2);
        do_cmp(0, 16'h00FF, 16'h00F0, 2'b01, 4);
        do_cmp(1, 16'h0000, 16'hFFFF, 2'b10, 16);
        do_cmp(1, 16'h0000, 16'h0007, 2'b11, 0);
        do_cmp(0, 16'h00FF, 16'h0000, 2'b10, 12);
        do_cmp(0, 16'h0003, 16'h0003, 2'b01, 0);
        do_cmp(0, 16'h0003, 16'h0001, 2'b01, 0);
        do_cmp(2, 16'h00C3, 16'h0000, 2'b10, 4);

        // Abort a compare mid-RUN with an asynchronous reset
        do_cmp(0, 16'h00FF, 16'h00F0, 2'b01, 4);
        @(negedge clk);
        sel = 0; t_a = 16'h00FF; t_b = 16'h0000; t_mode = 2'b11; t_start = 1'b1;
        repeat (3) @(negedge clk);
        t_start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
        check("arst_dist", o_dist, 0);
        check("arst_match", o_match, 0);
        @(negedge clk);
        check("arst_no_done", o_done, 0);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            prev_d[s] = 0;
            prev_m[s] = 0;
        end
        @(negedge clk);
        check("post_rst_idle", o_busy, 0);
        do_cmp(0, 16'h005A, 16'h00A5, 2'b00, 0);

        // Start held high: back-to-back compares with a 6-cycle period
        begin
            logic [15:0] ha = 16'($urandom) & 16'h00FF;
            logic [15:0] hb = 16'($urandom) & 16'h00FF;
            logic [1:0]  hm = 2'($urandom);
            int          hth = int'($urandom_range(0, 15));
            int          hd = ham(ha, hb, 8);
            @(negedge clk);
            sel = 2; t_a = ha; t_b = hb; t_mode = hm; t_thresh = 5'(hth); t_start = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                check("held_busy", o_busy, ((c % 6) < 4) ? 1 : 0);
                check("held_done", o_done, ((c % 6) == 5) ? 1 : 0);
                if ((c % 6) == 5) begin
                    check("held_dist", o_dist, hd);
                    check("held_match", o_match, verdict(int'(hm), hd, hth));
                end
            end
            t_start = 1'b0;
            prev_d[2] = hd;
            prev_m[2] = verdict(int'(hm), hd, hth);
            @(negedge clk);
            check("held_stop", o_busy, 0);
        end

        for (int r = 0; r < 30; r++) begin
            int          s = int'($urandom_range(0, 2));
            logic [15:0] ra = 16'($urandom);
            logic [15:0] rb = 16'($urandom);
            if ($urandom % 4 == 0) rb = ra;
            else if ($urandom % 3 == 0) rb = ra ^ (16'd1 << $urandom_range(0, 7));
            do_cmp(s, ra, rb, 2'($urandom),
                   int'($urandom_range(0, (1 << dwid(s)) - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
